// File: rtl/sum_window_if.sv
// rtl/sum_window_if.sv - sample-in / window-result-out handshake bundle for sum_window_accumulator
interface sum_window_if #(
    parameter int DATA_W      = 8,
    parameter int WINDOW_LOG2 = 2,
    parameter int ACC_W       = DATA_W + WINDOW_LOG2
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_avg;

    // master drives samples and consumes results; slave is the accumulator
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_avg,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_avg,
        input  out_ready
    );
endinterface

// File: rtl/sum_window_accumulator.sv
// rtl/sum_window_accumulator.sv - sums 2**WINDOW_LOG2 accepted samples, holds total and floor average
module sum_window_accumulator #(
    parameter int DATA_W      = 8,
    parameter int WINDOW_LOG2 = 2,
    parameter int ACC_W       = DATA_W + WINDOW_LOG2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    output logic           busy,
    sum_window_if.slave    s_if
);
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [WINDOW_LOG2-1:0] CNT_ONE = WINDOW_LOG2'(1);

    logic [0:0]             state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [WINDOW_LOG2-1:0] count_q, count_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_W-1:0]       out_sum_q, out_sum_d;
    logic [DATA_W-1:0]      out_avg_q, out_avg_d;

    logic                   accept;
    logic                   last_beat;
    logic [ACC_W-1:0]       acc_next;

    assign accept    = s_if.in_valid && (state_q == ST_ACCUM);
    assign last_beat = &count_q;
    // ACC_W leaves WINDOW_LOG2 bits of headroom, so this add can never wrap
    assign acc_next  = acc_q + ACC_W'(s_if.in_data);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_avg_d   = out_avg_q;

        if (clear) begin
            // drop partial window, any concurrent beat and any held result;
            // out_sum/out_avg keep stale contents since out_valid qualifies them
            state_d     = ST_ACCUM;
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (state_q == ST_HOLD) begin
            if (out_valid_q && s_if.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ST_ACCUM;
            end
        end else if (accept) begin
            if (last_beat) begin
                out_sum_d   = acc_next;
                out_avg_d   = acc_next[ACC_W-1:WINDOW_LOG2];
                out_valid_d = 1'b1;
                acc_d       = '0;
                count_d     = '0;
                state_d     = ST_HOLD;
            end else begin
                acc_d   = acc_next;
                count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
        end
    end

    assign s_if.in_ready  = (state_q == ST_ACCUM);
    assign s_if.out_valid = out_valid_q;
    assign s_if.out_sum   = out_sum_q;
    assign s_if.out_avg   = out_avg_q;
    assign busy           = (count_q != '0) || (state_q == ST_HOLD);
endmodule

// File: tb/tb_sum_window_accumulator.sv
// tb/tb_sum_window_accumulator.sv - table-driven, hand-sequenced and randomized checks of sum_window_accumulator
module tb_sum_window_accumulator;
    localparam int DW  = 8;
    localparam int WL  = 2;
    localparam int AW  = DW + WL;
    localparam int WIN = 1 << WL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic busy;

    sum_window_if #(.DATA_W(DW), .WINDOW_LOG2(WL)) bus ();

    sum_window_accumulator #(.DATA_W(DW), .WINDOW_LOG2(WL)) dut (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .busy (busy),
        .s_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
        logic       ordy;
        logic       e_ov;
        logic       e_ir;
        logic       e_busy;
        int         e_sum;
        int         e_avg;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    // reference: the open window is a list of samples; a held result is just a number
    logic [7:0] m_win[$];
    bit         m_held = 1'b0;
    int         m_sum  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win.delete();
        m_held = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c, input logic o);
        if (c) begin
            m_win.delete();
            m_held = 1'b0;
        end else if (m_held) begin
            if (o) m_held = 1'b0;
        end else if (v) begin
            m_win.push_back(d);
            if (m_win.size() == WIN) begin
                m_sum = 0;
                foreach (m_win[k]) m_sum += int'(m_win[k]);
                m_held = 1'b1;
                m_win.delete();
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic c, input logic o);
        bus.in_valid  = v;
        bus.in_data   = d;
        clear         = c;
        bus.out_ready = o;
        @(posedge clk);
        model_step(v, d, c, o);
        #1;
    endtask

    task automatic add(input logic v, input int d, input logic c, input logic o,
                       input logic ov, input logic ir, input logic b, input int s);
        vec_t r;
        r.v = v; r.d = 8'(d); r.clr = c; r.ordy = o;
        r.e_ov = ov; r.e_ir = ir; r.e_busy = b; r.e_sum = s; r.e_avg = s / WIN;
        tbl.push_back(r);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out_valid"}, int'(bus.out_valid), int'(m_held));
        chk({tag, "_in_ready"}, int'(bus.in_ready), int'(!m_held));
        chk({tag, "_busy"}, int'(busy), int'((m_win.size() != 0) || m_held));
        if (m_held) begin
            chk({tag, "_out_sum"}, int'(bus.out_sum), m_sum);
            chk({tag, "_out_avg"}, int'(bus.out_avg), m_sum / WIN);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // 1: 10,20,30,40 with out_ready=1
        add(1, 10, 0, 1, 0, 1, 1, 0);
        add(1, 20, 0, 1, 0, 1, 1, 0);
        add(1, 30, 0, 1, 0, 1, 1, 0);
        add(1, 40, 0, 1, 1, 0, 1, 100);
        add(0, 0, 0, 1, 0, 1, 0, 0);
        // 2: four beats of 255
        add(1, 255, 0, 0, 0, 1, 1, 0);
        add(1, 255, 0, 0, 0, 1, 1, 0);
        add(1, 255, 0, 0, 0, 1, 1, 0);
        add(1, 255, 0, 0, 1, 0, 1, 1020);
        add(0, 0, 0, 1, 0, 1, 0, 0);
        // 3: 1,2,3,4 then stalled while upstream offers 99
        add(1, 1, 0, 0, 0, 1, 1, 0);
        add(1, 2, 0, 0, 0, 1, 1, 0);
        add(1, 3, 0, 0, 0, 1, 1, 0);
        add(1, 4, 0, 0, 1, 0, 1, 10);
        for (int i = 0; i < 5; i++) add(1, 99, 0, 0, 1, 0, 1, 10);
        add(1, 99, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        // 4: gaps inside a window
        add(1, 1, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 2, 0, 0, 0, 1, 1, 0);
        add(1, 3, 0, 0, 0, 1, 1, 0);
        add(1, 4, 0, 0, 1, 0, 1, 10);
        add(0, 0, 0, 1, 0, 1, 0, 0);
        // 5: clear aborts 7,9 and discards concurrent 50
        add(1, 7, 0, 0, 0, 1, 1, 0);
        add(1, 9, 0, 0, 0, 1, 1, 0);
        add(1, 50, 1, 0, 0, 1, 0, 0);
        add(1, 5, 0, 0, 0, 1, 1, 0);
        add(1, 5, 0, 0, 0, 1, 1, 0);
        add(1, 5, 0, 0, 0, 1, 1, 0);
        add(1, 5, 0, 0, 1, 0, 1, 20);
        // clear drops a held result even with out_ready=1
        add(0, 0, 1, 1, 0, 1, 0, 0);
        add(1, 200, 0, 0, 0, 1, 1, 0);
        add(1, 201, 0, 0, 0, 1, 1, 0);
        add(1, 202, 0, 0, 0, 1, 1, 0);
        add(1, 203, 0, 0, 1, 0, 1, 806);

        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_avg", int'(bus.out_avg), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy);
            chk($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(tbl[i].e_ir));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_sum", i), int'(bus.out_sum), tbl[i].e_sum);
                chk($sformatf("vec%0d_out_avg", i), int'(bus.out_avg), tbl[i].e_avg);
            end
        end

        // 6: async reset while holding a result, between clock edges
        cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(1, 3, 0, 0);
        cycle(1, 4, 0, 0);
        chk("hold_before_rst", int'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", int'(bus.out_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_in_ready", int'(bus.in_ready), 1);
        #2 rst = 1'b0;
        model_reset();
        cycle(1, 11, 0, 0);
        cycle(1, 12, 0, 0);
        cycle(1, 13, 0, 0);
        cycle(1, 14, 0, 0);
        chk("post_rst_out_valid", int'(bus.out_valid), 1);
        chk("post_rst_out_sum", int'(bus.out_sum), 50);
        chk("post_rst_out_avg", int'(bus.out_avg), 12);
        cycle(0, 0, 0, 1);
        check_model("post_rst_drain");

        // randomized traffic against the queue-based reference
        for (int n = 0; n < 600; n++) begin
            logic       rv, rc, ro;
            logic [7:0] rd;
            rv = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            rc = ($urandom_range(0, 19) == 0);
            ro = ($urandom_range(0, 2) != 0);
            cycle(rv, rd, rc, ro);
            check_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
